prisoner_guess_seq: RTL

//   Upstream stimulus sequencer for the prisoners secret-compare stage. On start it

---
 rtl/prisoner_guess_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/prisoner_guess_seq.sv
// Stimulus sequencer for the prisoners secret-compare stage: it resets and loads the
// downstream stage, sweeps guesses, and records the first guess that matched the secret.
module prisoner_guess_seq #(
  parameter int          NUM_GUESSES = 50,
  parameter logic [31:0] GUARD_KEY   = 32'hCAFEFACE,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       secret_i,
  input  logic [7:0]       first_guess_i,
  input  logic [7:0]       stride_i,
  input  logic             hold_i,
  output logic             dn_rst_o,
  output logic [31:0]      guard_key_o,
  output logic             load_o,
  output logic             compare_o,
  output logic [7:0]       guess_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] hit_idx_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KRST  = 3'd1,
    LOAD  = 3'd2,
    GAP   = 3'd3,
    GUESS = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_GUESSES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       secret_q, secret_d;
  logic [7:0]       stride_q, stride_d;
  logic [7:0]       g_q, g_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_idx_q, hit_idx_d;
  logic             dn_rst_q, dn_rst_d;
  logic [31:0]      guard_key_q, guard_key_d;
  logic             load_q, load_d;
  logic             compare_q, compare_d;
  logic [7:0]       guess_data_q, guess_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    secret_d     = secret_q;
    stride_d     = stride_q;
    g_d          = g_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    dn_rst_d     = 1'b0;
    guard_key_d  = 32'h0;
    load_d       = 1'b0;
    compare_d    = 1'b0;
    guess_data_d = 8'h00;
    done_d       = 1'b0;

    // Outputs are registered from the current state, so each step shows one edge later.
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          secret_d  = secret_i;
          g_d       = first_guess_i;
          stride_d  = stride_i;
          hit_d     = 1'b0;
          hit_idx_d = '0;
          cnt_d     = '0;
          state_d   = KRST;
        end
      end
      KRST: begin
        dn_rst_d    = 1'b1;
        guard_key_d = GUARD_KEY;
        state_d     = LOAD;
      end
      LOAD: begin
        load_d       = 1'b1;
        guard_key_d  = GUARD_KEY;
        guess_data_d = secret_q;
        state_d      = GAP;
      end
      GAP: begin
        state_d = GUESS;
      end
      GUESS: begin
        if (hold_i) begin
          guess_data_d = guess_data_q;
        end else begin
          compare_d    = 1'b1;
          guess_data_d = g_q;
          g_d          = g_q + stride_q;
          cnt_d        = cnt_q + 1'b1;
          if ((g_q == secret_q) && !hit_q) begin
            hit_d     = 1'b1;
            hit_idx_d = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy rises with the accepted start and stays through the done pulse.
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      dn_rst_q     <= 1'b0;
      guard_key_q  <= 32'h0;
      load_q       <= 1'b0;
      compare_q    <= 1'b0;
      guess_data_q <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      dn_rst_q     <= dn_rst_d;
      guard_key_q  <= guard_key_d;
      load_q       <= load_d;
      compare_q    <= compare_d;
      guess_data_q <= guess_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Captured round parameters are only meaningful after a start, so they need no reset.
  always_ff @(posedge clk) begin
    secret_q <= secret_d;
    stride_q <= stride_d;
    g_q      <= g_d;
  end

  assign dn_rst_o     = dn_rst_q;
  assign guard_key_o  = guard_key_q;
  assign load_o       = load_q;
  assign compare_o    = compare_q;
  assign guess_data_o = guess_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign hit_o        = hit_q;
  assign hit_idx_o    = hit_idx_q;

endmodule
